iod_delay_train_ctrl: RTL and testbench
=======================================

IOD_DELAY_TRAIN_CTRL -- requirements
Module: iod_delay_train_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_LANES, default 1, giving the number of IOD lanes trained (1..8).
REQ-002 The block SHALL have parameter DATA_W, default 8, giving the RX_DATA width per lane.
REQ-003 The block SHALL have parameter TAP_W, default 8, giving the delay tap counter width.
REQ-004 The block SHALL have parameter MAX_TAPS, default 128, giving the sweep limit (at most 2^TAP_W).
REQ-005 The block SHALL have parameter SETTLE_CYC, default 16, giving the wait cycles after a flag clear before sampling (at least 1).
REQ-006 The block SHALL have parameter MIN_WIN, default 4, giving the minimum passing-window length in taps.
REQ-007 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-008 The block SHALL have the following ports (name, direction, width, meaning):
- FAB_CLK, in, 1: fabric clock; all logic on the rising edge.
- ARST, in, 1: asynchronous active-high reset.
- TRAIN_START, in, 1: single-cycle start request.
- TRAIN_MODE, in, 1: pass criterion. 0 = eye-monitor flags; 1 = RX_DATA stability.
- EYE_MONITOR_EARLY, in, NUM_LANES: per-lane early flag.
- EYE_MONITOR_LATE, in, NUM_LANES: per-lane late flag.
- RX_DATA, in, NUM_LANES*DATA_W: deserialised data; lane n occupies bits [n*DATA_W +: DATA_W].
- DELAY_LINE_OUT_OF_RANGE, in, NUM_LANES: per-lane delay-line limit reached.
- DELAY_LINE_MOVE, out, NUM_LANES: one-cycle pulse that steps the lane delay by one tap.
- DELAY_LINE_DIRECTION, out, NUM_LANES: step direction; 1 = increment.
- DELAY_LINE_LOAD, out, NUM_LANES: one-cycle pulse that reloads the lane delay to tap 0.
- EYE_MONITOR_CLEAR_FLAGS, out, NUM_LANES: one-cycle pulse that clears the lane flags.
- TRAIN_BUSY, out, 1: high from the accepted start until completion.
- TRAIN_DONE, out, 1: one-cycle completion pulse.
- TRAIN_ERR, out, NUM_LANES: sticky per-lane failure, valid after TRAIN_DONE.
- LANE_TAP, out, NUM_LANES*TAP_W: final centred tap per lane.

Function
REQ-009 The block SHALL sample TRAIN_START only in IDLE; a start received while TRAIN_BUSY is high SHALL be ignored.
REQ-010 On an accepted start the block SHALL clear TRAIN_ERR and LANE_TAP, latch TRAIN_MODE, set TRAIN_BUSY on the next cycle, and train lanes sequentially from 0 to NUM_LANES-1.
REQ-011 The block SHALL implement states IDLE, LOAD, CLEAR, SETTLE, SAMPLE, STEP, CALC, RELOAD, CENTER, NEXT and DONE.
REQ-012 Per-lane state flow SHALL be:
- LOAD: 1 cycle; pulse DELAY_LINE_LOAD; tap counter = 0; reset run trackers.
- CLEAR: 1 cycle; pulse EYE_MONITOR_CLEAR_FLAGS.
- SETTLE: exactly SETTLE_CYC cycles.
- SAMPLE: 1 cycle; evaluate pass.
- STEP: pulse DELAY_LINE_MOVE with DIRECTION=1; tap counter +1.
REQ-013 Each tap SHALL take exactly SETTLE_CYC+3 cycles.
REQ-014 Pass criterion SHALL be:
- mode 0: pass = !(EARLY|LATE) of the active lane;
- mode 1: pass = RX_DATA lane value at SAMPLE equals its value on the last SETTLE cycle.
REQ-015 The block SHALL track the current run start/length and the best run start/length (TAP_W+1 bits); the best run SHALL be replaced only by a strictly longer run, so on a tie the lowest run is kept.
REQ-016 The sweep SHALL end after SAMPLE when the tap counter equals MAX_TAPS-1, or when DELAY_LINE_OUT_OF_RANGE for the active lane is high at SAMPLE (no STEP follows); a run still open at sweep end SHALL be counted.
REQ-017 CALC (1 cycle) SHALL compute centre = best_start + floor(best_len/2); if best_len < MIN_WIN then centre = 0 and the lane's TRAIN_ERR bit SHALL be set.
REQ-018 RELOAD SHALL pulse DELAY_LINE_LOAD for 1 cycle; CENTER SHALL then issue exactly centre MOVE pulses with DIRECTION=1, one every 2 cycles (pulse, gap).
REQ-019 After CENTER the block SHALL write LANE_TAP[lane] = centre, then NEXT SHALL advance to the next lane's LOAD, or to DONE after the last lane.
REQ-020 DONE SHALL pulse TRAIN_DONE for 1 cycle, drop TRAIN_BUSY in the same cycle, and return to IDLE.
REQ-021 MOVE, LOAD and CLEAR pulses SHALL drive only the active lane's bit; all other lane bits SHALL stay 0.

Reset
REQ-022 While ARST is high, all outputs, the FSM (IDLE), counters and trackers SHALL be 0, including on assertion mid-operation; the first start after deassertion SHALL run normally.

Verification
REQ-023 NUM_LANES=1, mode 0, flags clear at taps 20..39 only -> LANE_TAP=30, TRAIN_ERR=0, 30 centring MOVE pulses, one TRAIN_DONE.
REQ-024 Pass windows 10..14 and 50..59 -> LANE_TAP=55; equal windows 10..17 and 40..47 -> LANE_TAP=14.
REQ-025 Flags never clear -> TRAIN_ERR=1, LANE_TAP=0, zero MOVE pulses after RELOAD.
REQ-026 Pass from tap 30 with OUT_OF_RANGE at tap 40 -> sweep stops at 40 with no further STEP, LANE_TAP=35.
REQ-027 ARST pulsed mid-SETTLE on lane 2 of 4 -> all outputs 0 at once; a later start trains all four lanes to the expected taps.
REQ-028 NUM_LANES=4, mode 1, per-lane windows centred at 8/16/24/32, a second start during BUSY -> LANE_TAP={32,24,16,8}, exactly one TRAIN_DONE.

Source files
------------

// File: rtl/iod_delay_train_ctrl.sv
// ---------------------------------------------------------------------------
// iod_delay_train_ctrl
//
// Purpose: trains the input delay of NUM_LANES IOD lanes one after another.
// For each lane the delay line is reloaded to tap 0 and swept upward one tap
// at a time. At every tap the eye-monitor flags are cleared, the lane is left
// to settle, then a pass/fail sample is taken. The longest run of passing taps
// (lowest run on a tie) is kept, its centre is computed, and the delay line is
// reloaded and stepped up to that centre.
//
// Ports:
//   FAB_CLK                 in   fabric clock, rising edge
//   ARST                    in   asynchronous active-high reset
//   TRAIN_START             in   single-cycle start request (sampled in IDLE)
//   TRAIN_MODE              in   0 = eye-monitor flags, 1 = RX_DATA stability
//   EYE_MONITOR_EARLY/LATE  in   per-lane eye flags
//   RX_DATA                 in   per-lane data, lane n at [n*DATA_W +: DATA_W]
//   DELAY_LINE_OUT_OF_RANGE in   per-lane delay-line limit flag
//   DELAY_LINE_MOVE         out  one-cycle step pulse, active lane only
//   DELAY_LINE_DIRECTION    out  step direction (1 = increment)
//   DELAY_LINE_LOAD         out  one-cycle reload-to-tap-0 pulse
//   EYE_MONITOR_CLEAR_FLAGS out  one-cycle flag clear pulse
//   TRAIN_BUSY              out  high while training
//   TRAIN_DONE              out  one-cycle completion pulse
//   TRAIN_ERR               out  sticky per-lane failure (window too small)
//   LANE_TAP                out  final centred tap per lane
// ---------------------------------------------------------------------------
module iod_delay_train_ctrl #(
    parameter int NUM_LANES  = 1,
    parameter int DATA_W     = 8,
    parameter int TAP_W      = 8,
    parameter int MAX_TAPS   = 128,
    parameter int SETTLE_CYC = 16,
    parameter int MIN_WIN    = 4
) (
    input  logic                       FAB_CLK,
    input  logic                       ARST,
    input  logic                       TRAIN_START,
    input  logic                       TRAIN_MODE,
    input  logic [NUM_LANES-1:0]       EYE_MONITOR_EARLY,
    input  logic [NUM_LANES-1:0]       EYE_MONITOR_LATE,
    input  logic [NUM_LANES*DATA_W-1:0] RX_DATA,
    input  logic [NUM_LANES-1:0]       DELAY_LINE_OUT_OF_RANGE,
    output logic [NUM_LANES-1:0]       DELAY_LINE_MOVE,
    output logic [NUM_LANES-1:0]       DELAY_LINE_DIRECTION,
    output logic [NUM_LANES-1:0]       DELAY_LINE_LOAD,
    output logic [NUM_LANES-1:0]       EYE_MONITOR_CLEAR_FLAGS,
    output logic                       TRAIN_BUSY,
    output logic                       TRAIN_DONE,
    output logic [NUM_LANES-1:0]       TRAIN_ERR,
    output logic [NUM_LANES*TAP_W-1:0] LANE_TAP
);

    localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int SET_W  = $clog2(SETTLE_CYC) + 1;

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_CLEAR, S_SETTLE, S_SAMPLE, S_STEP,
        S_CALC, S_RELOAD, S_CENTER, S_NEXT, S_DONE
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [LANE_W-1:0]          r_lane;
    logic [TAP_W-1:0]           r_tap;
    logic [SET_W-1:0]           r_settle_cnt;
    logic                       r_mode;
    logic [DATA_W-1:0]          r_prev_data;
    logic [TAP_W-1:0]           r_run_start;
    logic [TAP_W:0]             r_run_len;
    logic [TAP_W-1:0]           r_best_start;
    logic [TAP_W:0]             r_best_len;
    logic [TAP_W-1:0]           r_centre;
    logic [TAP_W-1:0]           r_move_cnt;
    logic                       r_gap;
    logic [NUM_LANES-1:0]       r_err;
    logic [NUM_LANES*TAP_W-1:0] r_lane_tap;

    logic [NUM_LANES-1:0] w_lane_oh;
    logic [DATA_W-1:0]    w_lane_data_arr [NUM_LANES];
    logic [DATA_W-1:0]    w_lane_data;
    logic                 w_early;
    logic                 w_late;
    logic                 w_oor;
    logic                 w_pass;
    logic                 w_sweep_end;
    logic                 w_last_lane;
    logic [TAP_W:0]       w_fin_len;
    logic [TAP_W-1:0]     w_fin_start;
    logic [TAP_W-1:0]     w_centre;
    logic                 w_short;
    logic                 w_center_move;
    logic                 w_center_done;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            assign w_lane_oh[gi]       = (r_lane == LANE_W'(gi));
            assign w_lane_data_arr[gi] = RX_DATA[gi*DATA_W +: DATA_W];
        end
    endgenerate

    assign w_lane_data = w_lane_data_arr[r_lane];
    assign w_early     = |(EYE_MONITOR_EARLY & w_lane_oh);
    assign w_late      = |(EYE_MONITOR_LATE & w_lane_oh);
    assign w_oor       = |(DELAY_LINE_OUT_OF_RANGE & w_lane_oh);

    // Mode 1 compares the sample against the value captured on the final
    // SETTLE cycle (r_prev_data is refreshed on every SETTLE cycle).
    assign w_pass      = r_mode ? (w_lane_data == r_prev_data) : !(w_early | w_late);
    assign w_sweep_end = (r_tap == TAP_W'(MAX_TAPS - 1)) || w_oor;
    assign w_last_lane = (r_lane == LANE_W'(NUM_LANES - 1));

    // A run still open when the sweep stops competes here; a failing sample
    // has already folded its closed run into the best tracker.
    assign w_fin_len   = (r_run_len > r_best_len) ? r_run_len : r_best_len;
    assign w_fin_start = (r_run_len > r_best_len) ? r_run_start : r_best_start;
    assign w_centre    = w_fin_start + w_fin_len[TAP_W:1];
    assign w_short     = (w_fin_len < (TAP_W+1)'(MIN_WIN));

    assign w_center_done = (r_move_cnt == r_centre);
    assign w_center_move = !w_center_done && !r_gap;

    assign TRAIN_ERR = r_err;
    assign LANE_TAP  = r_lane_tap;

    always_ff @(posedge FAB_CLK or posedge ARST) begin
        if (ARST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next            = r_state;
        DELAY_LINE_MOVE         = '0;
        DELAY_LINE_DIRECTION    = '0;
        DELAY_LINE_LOAD         = '0;
        EYE_MONITOR_CLEAR_FLAGS = '0;
        TRAIN_BUSY              = 1'b1;
        TRAIN_DONE              = 1'b0;
        case (r_state)
            S_IDLE: begin
                TRAIN_BUSY = 1'b0;
                if (TRAIN_START) w_state_next = S_LOAD;
            end
            S_LOAD: begin
                DELAY_LINE_LOAD = w_lane_oh;
                w_state_next    = S_CLEAR;
            end
            S_CLEAR: begin
                EYE_MONITOR_CLEAR_FLAGS = w_lane_oh;
                w_state_next            = S_SETTLE;
            end
            S_SETTLE: begin
                if (r_settle_cnt == SET_W'(SETTLE_CYC - 1)) w_state_next = S_SAMPLE;
            end
            S_SAMPLE: begin
                w_state_next = w_sweep_end ? S_CALC : S_STEP;
            end
            S_STEP: begin
                DELAY_LINE_MOVE      = w_lane_oh;
                DELAY_LINE_DIRECTION = w_lane_oh;
                w_state_next         = S_CLEAR;
            end
            S_CALC: begin
                w_state_next = S_RELOAD;
            end
            S_RELOAD: begin
                DELAY_LINE_LOAD = w_lane_oh;
                w_state_next    = S_CENTER;
            end
            S_CENTER: begin
                if (w_center_move) begin
                    DELAY_LINE_MOVE      = w_lane_oh;
                    DELAY_LINE_DIRECTION = w_lane_oh;
                end
                if (w_center_done) w_state_next = S_NEXT;
            end
            S_NEXT: begin
                w_state_next = w_last_lane ? S_DONE : S_LOAD;
            end
            S_DONE: begin
                TRAIN_BUSY   = 1'b0;
                TRAIN_DONE   = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                TRAIN_BUSY   = 1'b0;
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge FAB_CLK or posedge ARST) begin
        if (ARST) begin
            r_lane       <= '0;
            r_tap        <= '0;
            r_settle_cnt <= '0;
            r_mode       <= 1'b0;
            r_prev_data  <= '0;
            r_run_start  <= '0;
            r_run_len    <= '0;
            r_best_start <= '0;
            r_best_len   <= '0;
            r_centre     <= '0;
            r_move_cnt   <= '0;
            r_gap        <= 1'b0;
            r_err        <= '0;
            r_lane_tap   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (TRAIN_START) begin
                        r_mode     <= TRAIN_MODE;
                        r_err      <= '0;
                        r_lane_tap <= '0;
                        r_lane     <= '0;
                    end
                end
                S_LOAD: begin
                    r_tap        <= '0;
                    r_run_start  <= '0;
                    r_run_len    <= '0;
                    r_best_start <= '0;
                    r_best_len   <= '0;
                end
                S_CLEAR: begin
                    r_settle_cnt <= '0;
                end
                S_SETTLE: begin
                    r_settle_cnt <= r_settle_cnt + 1'b1;
                    r_prev_data  <= w_lane_data;
                end
                S_SAMPLE: begin
                    if (w_pass) begin
                        if (r_run_len == '0) r_run_start <= r_tap;
                        r_run_len <= r_run_len + 1'b1;
                    end else begin
                        // Strictly longer only, so the lowest run wins a tie.
                        if (r_run_len > r_best_len) begin
                            r_best_start <= r_run_start;
                            r_best_len   <= r_run_len;
                        end
                        r_run_len <= '0;
                    end
                end
                S_STEP: begin
                    r_tap <= r_tap + 1'b1;
                end
                S_CALC: begin
                    r_centre   <= w_short ? '0 : w_centre;
                    r_move_cnt <= '0;
                    r_gap      <= 1'b0;
                    if (w_short) r_err <= r_err | w_lane_oh;
                end
                S_CENTER: begin
                    if (!w_center_done) begin
                        // Alternate pulse and gap; count a move once its gap ends.
                        r_gap <= !r_gap;
                        if (r_gap) r_move_cnt <= r_move_cnt + 1'b1;
                    end else begin
                        for (int l = 0; l < NUM_LANES; l++) begin
                            if (w_lane_oh[l]) r_lane_tap[l*TAP_W +: TAP_W] <= r_centre;
                        end
                    end
                end
                S_NEXT: begin
                    if (!w_last_lane) r_lane <= r_lane + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iod_delay_train_ctrl.sv
// ---------------------------------------------------------------------------
// tb_iod_delay_train_ctrl
//
// Drives a 4-lane instance against a simple delay-line plant: each lane has a
// tap position moved by the DUT's LOAD/MOVE pulses, and pass windows (up to
// two per lane) decide the eye flags / data stability at the current tap.
// The expected output trace is built from the window description and the
// per-tap timing, then compared cycle by cycle.
// ---------------------------------------------------------------------------
module tb_iod_delay_train_ctrl;

    localparam int NL = 4;
    localparam int DW = 8;
    localparam int TW = 8;
    localparam int MT = 64;
    localparam int SC = 4;
    localparam int MW = 4;

    logic             clk = 1'b0;
    logic             arst;
    logic             start;
    logic             mode_in;
    logic [NL-1:0]    early;
    logic [NL-1:0]    late;
    logic [NL*DW-1:0] rx;
    logic [NL-1:0]    oor;
    logic [NL-1:0]    dl_move;
    logic [NL-1:0]    dl_dir;
    logic [NL-1:0]    dl_load;
    logic [NL-1:0]    clr_flags;
    logic             busy;
    logic             done;
    logic [NL-1:0]    err;
    logic [NL*TW-1:0] lane_tap;

    iod_delay_train_ctrl #(
        .NUM_LANES(NL), .DATA_W(DW), .TAP_W(TW),
        .MAX_TAPS(MT), .SETTLE_CYC(SC), .MIN_WIN(MW)
    ) dut (
        .FAB_CLK(clk),
        .ARST(arst),
        .TRAIN_START(start),
        .TRAIN_MODE(mode_in),
        .EYE_MONITOR_EARLY(early),
        .EYE_MONITOR_LATE(late),
        .RX_DATA(rx),
        .DELAY_LINE_OUT_OF_RANGE(oor),
        .DELAY_LINE_MOVE(dl_move),
        .DELAY_LINE_DIRECTION(dl_dir),
        .DELAY_LINE_LOAD(dl_load),
        .EYE_MONITOR_CLEAR_FLAGS(clr_flags),
        .TRAIN_BUSY(busy),
        .TRAIN_DONE(done),
        .TRAIN_ERR(err),
        .LANE_TAP(lane_tap)
    );

    always #5 clk = ~clk;

    // ---------------- plant ----------------
    int       ws0 [NL];
    int       wl0 [NL];
    int       ws1 [NL];
    int       wl1 [NL];
    int       oor_t [NL];
    int       p_tap [NL];
    bit [7:0] noise = 8'd0;
    int       scen_mode = 0;

    function automatic bit in_win(int l, int t);
        return (t >= ws0[l] && t < ws0[l] + wl0[l]) || (t >= ws1[l] && t < ws1[l] + wl1[l]);
    endfunction

    always @(posedge clk) begin
        noise <= noise + 8'd1;
        for (int l = 0; l < NL; l++) begin
            if (dl_load[l]) p_tap[l] <= 0;
            else if (dl_move[l] && dl_dir[l]) p_tap[l] <= p_tap[l] + 1;
        end
    end

    // Mode 0 scenarios keep RX_DATA changing every cycle and mode 1 scenarios
    // keep a flag set, so only the latched criterion can see the window.
    always_comb begin
        early = '0;
        late  = '0;
        rx    = '0;
        oor   = '0;
        for (int l = 0; l < NL; l++) begin
            if (scen_mode == 0) begin
                early[l] = in_win(l, p_tap[l]) ? 1'b0 : noise[0];
                late[l]  = in_win(l, p_tap[l]) ? 1'b0 : ~noise[0];
                rx[l*DW +: DW] = noise + 8'(l * 37);
            end else begin
                early[l] = 1'b1;
                rx[l*DW +: DW] = in_win(l, p_tap[l]) ? (8'h5A ^ 8'(l)) : (noise + 8'(l * 37));
            end
            oor[l] = (p_tap[l] >= oor_t[l]);
        end
    end

    // ---------------- expected trace ----------------
    logic [53:0] exp_q[$];
    int          lane2_idx;
    int          n_checks = 0;
    int          n_pass = 0;
    int          moves0;
    int          dones;

    function automatic logic [53:0] pack(logic [3:0] mv, logic [3:0] dr, logic [3:0] ld,
                                         logic [3:0] cl, logic bz, logic dn,
                                         logic [3:0] er, logic [31:0] tp);
        return {mv, dr, ld, cl, bz, dn, er, tp};
    endfunction

    task automatic build_expected();
        logic [3:0]  e_err = '0;
        logic [31:0] e_tap = '0;
        exp_q.delete();
        lane2_idx = -1;
        for (int l = 0; l < NL; l++) begin
            logic [3:0] oh = 4'(1 << l);
            int last = (oor_t[l] < MT - 1) ? oor_t[l] : MT - 1;
            int bs = 0;
            int bl = 0;
            int c;
            exp_q.push_back(pack(0, 0, oh, 0, 1, 0, e_err, e_tap));           // LOAD
            for (int t = 0; t <= last; t++) begin
                exp_q.push_back(pack(0, 0, 0, oh, 1, 0, e_err, e_tap));       // CLEAR
                for (int s = 0; s < SC; s++) begin
                    if (l == 2 && t == 2 && s == 1) lane2_idx = exp_q.size();
                    exp_q.push_back(pack(0, 0, 0, 0, 1, 0, e_err, e_tap));    // SETTLE
                end
                exp_q.push_back(pack(0, 0, 0, 0, 1, 0, e_err, e_tap));        // SAMPLE
                if (t < last) exp_q.push_back(pack(oh, oh, 0, 0, 1, 0, e_err, e_tap));
            end
            // longest passing run among sampled taps, first one on a tie
            for (int s = 0; s <= last; s++) begin
                if (in_win(l, s) && (s == 0 || !in_win(l, s - 1))) begin
                    int len = 0;
                    while (s + len <= last && in_win(l, s + len)) len++;
                    if (len > bl) begin bs = s; bl = len; end
                end
            end
            c = (bl < MW) ? 0 : bs + bl / 2;
            exp_q.push_back(pack(0, 0, 0, 0, 1, 0, e_err, e_tap));            // CALC
            if (bl < MW) e_err[l] = 1'b1;
            exp_q.push_back(pack(0, 0, oh, 0, 1, 0, e_err, e_tap));           // RELOAD
            for (int k = 0; k < c; k++) begin
                exp_q.push_back(pack(oh, oh, 0, 0, 1, 0, e_err, e_tap));
                exp_q.push_back(pack(0, 0, 0, 0, 1, 0, e_err, e_tap));
            end
            exp_q.push_back(pack(0, 0, 0, 0, 1, 0, e_err, e_tap));            // CENTER end
            e_tap[l*8 +: 8] = 8'(c);
            exp_q.push_back(pack(0, 0, 0, 0, 1, 0, e_err, e_tap));            // NEXT
        end
        exp_q.push_back(pack(0, 0, 0, 0, 0, 1, e_err, e_tap));                // DONE
        exp_q.push_back(pack(0, 0, 0, 0, 0, 0, e_err, e_tap));                // IDLE
    endtask

    function automatic logic [53:0] dut_vec();
        return pack(dl_move, dl_dir, dl_load, clr_flags, busy, done, err, lane_tap);
    endfunction

    task automatic check(string name, int idx, logic [63:0] act, logic [63:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s idx=%0d actual=%h required=%h", name, idx, act, expv);
    endtask

    task automatic run_train(int m, bit do_abort, int dup_at);
        scen_mode = m;
        build_expected();
        moves0 = 0;
        dones  = 0;
        @(negedge clk);
        start   = 1'b1;
        mode_in = m[0];
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            start   = (i == dup_at);
            mode_in = 1'($urandom);
            check("trace", i, 64'(dut_vec()), 64'(exp_q[i]));
            moves0 += int'(dl_move[0]);
            dones  += int'(done);
            if (do_abort && i == lane2_idx) begin
                arst = 1'b1;
                #1;
                check("arst_outputs_zero", i, 64'(dut_vec()), 64'd0);
                repeat (3) @(negedge clk);
                arst = 1'b0;
                break;
            end
        end
        start = 1'b0;
        $display("run mode=%0d abort=%0d lane_tap=%h err=%b moves0=%0d dones=%0d",
                 m, do_abort, lane_tap, err, moves0, dones);
    endtask

    task automatic set_win(int l, int s0, int l0, int s1, int l1, int ot);
        ws0[l] = s0; wl0[l] = l0; ws1[l] = s1; wl1[l] = l1; oor_t[l] = ot;
    endtask

    task automatic rand_lanes(int first);
        for (int l = first; l < NL; l++) begin
            set_win(l, $urandom_range(0, 55), $urandom_range(0, 14),
                    $urandom_range(0, 55), $urandom_range(0, 14),
                    ($urandom_range(0, 3) == 0) ? $urandom_range(10, 63) : 255);
        end
    endtask

    task automatic set_028();
        set_win(0, 4, 9, 0, 0, 255);
        set_win(1, 12, 9, 0, 0, 255);
        set_win(2, 20, 9, 0, 0, 255);
        set_win(3, 28, 9, 0, 0, 255);
    endtask

    initial begin
        arst    = 1'b1;
        start   = 1'b0;
        mode_in = 1'b0;
        for (int l = 0; l < NL; l++) set_win(l, 0, 0, 0, 0, 255);
        repeat (3) @(negedge clk);
        check("reset_outputs", 0, 64'(dut_vec()), 64'd0);
        arst = 1'b0;
        @(negedge clk);
        check("idle_outputs", 0, 64'(dut_vec()), 64'd0);

        // single window 20..39
        rand_lanes(1);
        set_win(0, 20, 20, 0, 0, 255);
        run_train(0, 1'b0, -1);
        check("w20_39_tap", 0, 64'(lane_tap[7:0]), 64'd30);
        check("w20_39_err", 0, 64'(err[0]), 64'd0);
        check("w20_39_moves", 0, 64'(moves0), 64'd93);
        check("w20_39_dones", 0, 64'(dones), 64'd1);

        // longer second window wins
        rand_lanes(1);
        set_win(0, 10, 5, 50, 10, 255);
        run_train(0, 1'b0, -1);
        check("w_longer_tap", 0, 64'(lane_tap[7:0]), 64'd55);

        // tie keeps the lower window (mode 1)
        rand_lanes(1);
        set_win(0, 10, 8, 40, 8, 255);
        run_train(1, 1'b0, -1);
        check("w_tie_tap", 0, 64'(lane_tap[7:0]), 64'd14);

        // never passes
        rand_lanes(1);
        set_win(0, 0, 0, 0, 0, 255);
        run_train(0, 1'b0, -1);
        check("nopass_err", 0, 64'(err[0]), 64'd1);
        check("nopass_tap", 0, 64'(lane_tap[7:0]), 64'd0);
        check("nopass_moves", 0, 64'(moves0), 64'd63);

        // out-of-range stops the sweep at 40
        rand_lanes(1);
        set_win(0, 30, 34, 0, 0, 40);
        run_train(0, 1'b0, -1);
        check("oor_tap", 0, 64'(lane_tap[7:0]), 64'd35);
        check("oor_moves", 0, 64'(moves0), 64'd75);

        // reset mid-SETTLE of lane 2, then a clean run
        set_028();
        run_train(0, 1'b1, -1);
        run_train(0, 1'b0, -1);
        check("after_arst_taps", 0, 64'(lane_tap), 64'h20181008);

        // mode 1, second start while busy is ignored
        set_028();
        run_train(1, 1'b0, 100);
        check("m1_taps", 0, 64'(lane_tap), 64'h20181008);
        check("m1_dones", 0, 64'(dones), 64'd1);

        // random scenarios
        for (int r = 0; r < 3; r++) begin
            rand_lanes(0);
            run_train(int'($urandom_range(0, 1)), 1'b0, int'($urandom_range(20, 400)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
